// File: rtl/bfm_apb_responder.sv
// rtl/bfm_apb_responder.sv - APB3 completer BFM: word memory, programmable waits, range-error response
// Optional feature macro: BFM_APB_RESPONDER_RANDWAIT_EN (LFSR-driven random wait states)
module bfm_apb_responder #(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MAX_WAIT    = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned TPD         = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic [AWIDTH-1:0]   addr_q;
  logic                write_q;
  logic                err_q;
  logic [3:0]          cnt;
  logic [3:0]          wait_load;
  logic                setup;
  logic                range_err;
  logic                mem_we;
  logic [31:0]         mem [0:(1<<AWIDTH)-1];

  // Outputs are registered, so TPD has no cycle-level effect here; PADDR[1:0] is don't-care.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], 32'(TPD), 32'(WAIT_STATES), 32'(MAX_WAIT), LFSR_SEED};

  assign setup     = PSEL && !PENABLE;
  assign range_err = (PADDR[31:AWIDTH+2] != '0);

`ifdef BFM_APB_RESPONDER_RANDWAIT_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  // Galois form of x^8+x^6+x^5+x^4+1, shifting toward bit 0.
  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign wait_load = 4'({28'b0, lfsr[3:0]} % (MAX_WAIT + 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      lfsr <= LFSR_SEED;
    end else if (state == IDLE && setup) begin
      lfsr <= lfsr_next;
    end
  end
`else
  assign wait_load = 4'(WAIT_STATES);
`endif

  // Reset wins over a completing write so a pending transfer is discarded.
  assign mem_we = !PRESET && (state == ACCESS) && PSEL && (cnt == 4'd0) && write_q && !err_q;

  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      mem[addr_q] <= PWDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= 32'h0;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= PADDR[AWIDTH+1:2];
            write_q <= PWRITE;
            err_q   <= range_err;
            cnt     <= wait_load;
            PREADY  <= (wait_load == 4'd0);
            PSLVERR <= (wait_load == 4'd0) && range_err;
            if (!PWRITE) begin
              PRDATA <= range_err ? 32'h0 : mem[PADDR[AWIDTH+1:2]];
            end
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
`ifndef SYNTHESIS
            $display("%m: warning: PSEL dropped before completion, transfer to word 0x%0h discarded", addr_q);
`endif
          end else if (cnt == 4'd0) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (PENABLE) begin
            cnt     <= cnt - 4'd1;
            PREADY  <= (cnt == 4'd1);
            PSLVERR <= (cnt == 4'd1) && err_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfm_apb_responder.sv
// tb/tb_bfm_apb_responder.sv - directed vector bench for bfm_apb_responder (fixed 0/3-wait instances)
module tb_bfm_apb_responder;

  localparam int MAXW = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stray = 0;
  logic [7:0] lf [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if ((pslverr0 && !pready0) || (pslverr1 && !pready1)) stray++;

  bfm_apb_responder #(.AWIDTH(10), .WAIT_STATES(0), .MAX_WAIT(MAXW), .LFSR_SEED(SEED), .TPD(1)) u0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  bfm_apb_responder #(.AWIDTH(10), .WAIT_STATES(3), .MAX_WAIT(MAXW), .LFSR_SEED(SEED), .TPD(1)) u1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

  function automatic logic rdy(input int inst);
    return inst == 1 ? pready1 : pready0;
  endfunction
  function automatic logic errv(input int inst);
    return inst == 1 ? pslverr1 : pslverr0;
  endfunction
  function automatic logic [31:0] rdv(input int inst);
    return inst == 1 ? prdata1 : prdata0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", nm, act, exp);
    end
  endtask

  // Reference wait count for the next accepted setup on an instance.
  task automatic next_wait(input int inst, output int w);
`ifdef BFM_APB_RESPONDER_RANDWAIT_EN
    w = int'(lf[inst][3:0]) % (MAXW + 1);
    lf[inst] = {1'b0, lf[inst][7:1]} ^ (lf[inst][0] ? 8'hB8 : 8'h00);
`else
    w = (inst == 1) ? 3 : 0;
`endif
  endtask

  task automatic xfer(input int inst, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int waits, output bit ok);
    psel    = (inst == 1) ? 2'b10 : 2'b01;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    ok = 1'b0;
    rd = 32'h0;
    er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rdy(inst)) begin
        rd = rdv(inst);
        er = errv(inst);
        ok = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    psel = 2'b00;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        v [10];
  logic [31:0] rd;
  logic        er;
  int          waits, w, start, exp_cyc;
  bit          ok;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // For writes exp_rd is the PRDATA value left by the last read on that instance.
    v[0] = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    v[1] = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    v[2] = '{1, 1'b1, 32'h3FC,      32'hA5A55A5A, 32'h0,        1'b0};
    v[3] = '{1, 1'b0, 32'h3FC,      32'h0,        32'hA5A55A5A, 1'b0};
    v[4] = '{0, 1'b1, 32'h0,        32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
    v[5] = '{0, 1'b1, 32'h1000,     32'h00001234, 32'hDEADBEEF, 1'b1};
    v[6] = '{0, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1};
    v[7] = '{0, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
    v[8] = '{1, 1'b0, 32'h3FFC,     32'h0,        32'h0,        1'b1};
    v[9] = '{1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};

    lf[0] = SEED;
    lf[1] = SEED;
    rst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready0",  32'(pready0),  32'h0);
    chk("rst_pslverr0", 32'(pslverr0), 32'h0);
    chk("rst_prdata0",  prdata0,       32'h0);
    chk("rst_pready1",  32'(pready1),  32'h0);
    chk("rst_pslverr1", 32'(pslverr1), 32'h0);
    chk("rst_prdata1",  prdata1,       32'h0);
    rst = 1'b0;
    idle();

    for (int i = 0; i < 10; i++) begin
      next_wait(v[i].inst, w);
      xfer(v[i].inst, v[i].wr, v[i].addr, v[i].wd, rd, er, waits, ok);
      idle();
      chk($sformatf("v%0d_done", i),  32'(ok),    32'h1);
      chk($sformatf("v%0d_waits", i), 32'(waits), 32'(w));
      chk($sformatf("v%0d_err", i),   32'(er),    32'(v[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rd,         v[i].exp_rd);
`ifdef BFM_APB_RESPONDER_RANDWAIT_EN
      chk($sformatf("v%0d_wait_bound", i), 32'(waits <= MAXW), 32'h1);
`endif
    end

    // Back-to-back: 8 writes then 8 reads with no idle cycles between transfers.
    start = cyc;
    exp_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      next_wait(0, w);
      exp_cyc += w + 2;
      if (i < 8) begin
        xfer(0, 1'b1, 32'h100 + 32'(i) * 4, 32'h5A000000 + 32'(i) * 32'h01010101, rd, er, waits, ok);
      end else begin
        xfer(0, 1'b0, 32'h100 + 32'(i - 8) * 4, 32'h0, rd, er, waits, ok);
        chk($sformatf("b2b_rd%0d", i - 8), rd, 32'h5A000000 + 32'(i - 8) * 32'h01010101);
      end
    end
    chk("b2b_cycles", 32'(cyc - start), 32'(exp_cyc));
    idle();

    // Abort: PSEL drops after one access cycle of a write to 0x20.
    next_wait(1, w);
    xfer(1, 1'b1, 32'h20, 32'h11112222, rd, er, waits, ok);
    idle();
    next_wait(1, w);
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h99999999;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", 32'(pready1), 32'h0);
    next_wait(1, waits);
    xfer(1, 1'b0, 32'h20, 32'h0, rd, er, waits, ok);
    idle();
    chk("abort_mem", rd, (w == 0) ? 32'h99999999 : 32'h11112222);

    // Reset asserted during the access phase of a write to 0x24.
    next_wait(1, w);
    xfer(1, 1'b1, 32'h24, 32'h0BADF00D, rd, er, waits, ok);
    idle();
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h77777777;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 2'b00; penable = 1'b0;
    lf[0] = SEED;
    lf[1] = SEED;
    chk("rst_acc_pready",  32'(pready1),  32'h0);
    chk("rst_acc_pslverr", 32'(pslverr1), 32'h0);
    chk("rst_acc_prdata",  prdata1,       32'h0);
    @(posedge clk); #1;
    next_wait(1, w);
    xfer(1, 1'b0, 32'h24, 32'h0, rd, er, waits, ok);
    idle();
    chk("rst_acc_mem",   rd,          32'h0BADF00D);
    chk("rst_acc_waits", 32'(waits),  32'(w));

    chk("pslverr_only_with_pready", 32'(stray), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
